// File: rtl/gex_leak_scheduler.sv
// gex_leak_scheduler
//
// Streams every neuron's excitatory conductance (gex) through one shared
// combinational leak unit once per timestep and writes the decayed value
// back to the same RAM address. One neuron per cycle when not stalled.
//
// Pipeline (one item per column):
//   RUN cycle   : GexRdEn/GexRdAddr issued (held off while Stall is high)
//   +1 cycle    : RAM data valid, captured into LeakGex / stage-1 address
//   +2 cycle    : LeakGex stable all cycle, LeakGexOut written back
//
// Handshake: there is no ready path. Start is a single-cycle request taken
// only in IDLE; Stall only suppresses new reads and never freezes items
// already in flight, so read and write addresses stay paired.
//
// Ports:
//   Clock, Reset                  clock, async active-high reset
//   Start, NumNeurons,
//   DeltaT_In, Taugex_In          pass request and operands (sampled on Start)
//   Stall                         holds off new RAM reads
//   GexRdEn/GexRdAddr/GexRdData   gex RAM read port (1-cycle latency)
//   LeakGex/LeakDeltaT/LeakTaugex operands to the leak unit
//   LeakGexOut                    combinational leak result
//   GexWrEn/GexWrAddr/GexWrData   gex RAM write port
//   Busy, Done, Error             status to the timestep controller
module gex_leak_scheduler #(
  parameter int INTEGER_WIDTH     = 32,
  parameter int DATA_WIDTH_FRAC   = 32,
  parameter int DATA_WIDTH        = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int DELTAT_WIDTH      = 4,
  parameter int NEURON_ADDR_WIDTH = 8
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic [NEURON_ADDR_WIDTH:0]   NumNeurons,
  input  logic [DELTAT_WIDTH-1:0]      DeltaT_In,
  input  logic [INTEGER_WIDTH-1:0]     Taugex_In,
  input  logic                         Stall,
  output logic                         GexRdEn,
  output logic [NEURON_ADDR_WIDTH-1:0] GexRdAddr,
  input  logic [DATA_WIDTH-1:0]        GexRdData,
  output logic [DATA_WIDTH-1:0]        LeakGex,
  output logic [DELTAT_WIDTH-1:0]      LeakDeltaT,
  output logic [INTEGER_WIDTH-1:0]     LeakTaugex,
  input  logic [DATA_WIDTH-1:0]        LeakGexOut,
  output logic                         GexWrEn,
  output logic [NEURON_ADDR_WIDTH-1:0] GexWrAddr,
  output logic [DATA_WIDTH-1:0]        GexWrData,
  output logic                         Busy,
  output logic                         Done,
  output logic                         Error
);

  localparam int AW = NEURON_ADDR_WIDTH;
  localparam int CW = NEURON_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]            cnt_q, cnt_d;
  logic [CW-1:0]            num_q, num_d;
  logic [DELTAT_WIDTH-1:0]  dt_q, dt_d;
  logic [INTEGER_WIDTH-1:0] tau_q, tau_d;
  logic                     err_q, err_d;
  logic                     rd_v_q, rd_v_d;
  logic [AW-1:0]            rd_addr_q, rd_addr_d;
  logic                     s1_v_q, s1_v_d;
  logic [AW-1:0]            s1_addr_q, s1_addr_d;
  logic [DATA_WIDTH-1:0]    leak_gex_q, leak_gex_d;

  logic start_acc;
  logic abort_req;
  logic last_read;
  logic rd_en;
  logic done;
  logic busy;

  assign start_acc = (state_q == S_IDLE) && Start;
  assign abort_req = (Taugex_In == '0) || (NumNeurons == '0);
  // num_q >= 1 whenever RUN is entered, so the subtraction cannot wrap.
  assign last_read = ({1'b0, cnt_q} == (num_q - CW'(1)));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = abort_req ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        if (!Stall && last_read) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave when both stage valid bits will be clear next cycle: no new
        // reads are issued here, so stage 1 empties once the read stage does.
        // This lets FINISH follow the final write directly.
        if (!rd_v_q) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_en = 1'b0;
    done  = 1'b0;
    busy  = 1'b0;
    case (state_q)
      S_IDLE:   ;
      S_RUN: begin
        rd_en = !Stall;
        busy  = 1'b1;
      end
      S_DRAIN: begin
        busy = 1'b1;
      end
      S_FINISH: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default:  ;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_comb begin
    cnt_d      = cnt_q;
    num_d      = num_q;
    dt_d       = dt_q;
    tau_d      = tau_q;
    err_d      = err_q;
    rd_v_d     = rd_en;
    rd_addr_d  = rd_addr_q;
    s1_v_d     = rd_v_q;
    s1_addr_d  = s1_addr_q;
    leak_gex_d = leak_gex_q;

    if (start_acc) begin
      cnt_d = '0;
      num_d = NumNeurons;
      dt_d  = DeltaT_In;
      tau_d = Taugex_In;
      err_d = (Taugex_In == '0);
    end else if (rd_en) begin
      cnt_d = cnt_q + AW'(1);
    end

    if (rd_en) begin
      rd_addr_d = cnt_q;
    end

    // RAM data for the read issued last cycle is valid now.
    if (rd_v_q) begin
      leak_gex_d = GexRdData;
      s1_addr_d  = rd_addr_q;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q      <= '0;
      num_q      <= '0;
      dt_q       <= '0;
      tau_q      <= '0;
      err_q      <= 1'b0;
      rd_v_q     <= 1'b0;
      rd_addr_q  <= '0;
      s1_v_q     <= 1'b0;
      s1_addr_q  <= '0;
      leak_gex_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      num_q      <= num_d;
      dt_q       <= dt_d;
      tau_q      <= tau_d;
      err_q      <= err_d;
      rd_v_q     <= rd_v_d;
      rd_addr_q  <= rd_addr_d;
      s1_v_q     <= s1_v_d;
      s1_addr_q  <= s1_addr_d;
      leak_gex_q <= leak_gex_d;
    end
  end

  // ------------------------------------------------------------ outputs
  // Address and data buses are forced to zero when their enable is low so
  // every output reads 0 while Reset is held.
  assign GexRdEn    = rd_en;
  assign GexRdAddr  = rd_en ? cnt_q : '0;
  assign LeakGex    = leak_gex_q;
  assign LeakDeltaT = dt_q;
  assign LeakTaugex = tau_q;
  assign GexWrEn    = s1_v_q;
  assign GexWrAddr  = s1_v_q ? s1_addr_q : '0;
  assign GexWrData  = s1_v_q ? LeakGexOut : '0;
  assign Busy       = busy;
  assign Done       = done;
  assign Error      = done && err_q;

endmodule

// File: tb/tb_gex_leak_scheduler.sv
// tb_gex_leak_scheduler
//
// Bench for gex_leak_scheduler. The bench owns the gex RAM (1-cycle read
// latency) and the combinational leak unit. For each pass a reference model
// derives, from the stall pattern and the pass operands, the cycle of every
// read and write, the write contents and the Done cycle; a compare process
// checks the DUT against it every cycle on the falling edge.
module tb_gex_leak_scheduler;

  localparam int IW   = 32;
  localparam int DW   = 64;
  localparam int TW   = 4;
  localparam int AW   = 8;
  localparam int W    = AW + DW;
  localparam int MAXC = 700;

  // ------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic [AW:0]   NumNeurons = '0;
  logic [TW-1:0] DeltaT_In = '0;
  logic [IW-1:0] Taugex_In = '0;
  logic          Stall = 1'b0;
  logic          GexRdEn;
  logic [AW-1:0] GexRdAddr;
  logic [DW-1:0] GexRdData;
  logic [DW-1:0] LeakGex;
  logic [TW-1:0] LeakDeltaT;
  logic [IW-1:0] LeakTaugex;
  logic [DW-1:0] LeakGexOut;
  logic          GexWrEn;
  logic [AW-1:0] GexWrAddr;
  logic [DW-1:0] GexWrData;
  logic          Busy;
  logic          Done;
  logic          Error;

  gex_leak_scheduler dut (
    .Clock      (clk),
    .Reset      (Reset),
    .Start      (Start),
    .NumNeurons (NumNeurons),
    .DeltaT_In  (DeltaT_In),
    .Taugex_In  (Taugex_In),
    .Stall      (Stall),
    .GexRdEn    (GexRdEn),
    .GexRdAddr  (GexRdAddr),
    .GexRdData  (GexRdData),
    .LeakGex    (LeakGex),
    .LeakDeltaT (LeakDeltaT),
    .LeakTaugex (LeakTaugex),
    .LeakGexOut (LeakGexOut),
    .GexWrEn    (GexWrEn),
    .GexWrAddr  (GexWrAddr),
    .GexWrData  (GexWrData),
    .Busy       (Busy),
    .Done       (Done),
    .Error      (Error)
  );

  // ------------------------------------------------ leak unit and RAM
  function automatic logic [DW-1:0] leak_fn(input logic [DW-1:0] g,
                                            input logic [TW-1:0] dt,
                                            input logic [IW-1:0] tau);
    return g - ((g >> tau) * {{(DW-TW){1'b0}}, dt});
  endfunction

  assign LeakGexOut = leak_fn(LeakGex, LeakDeltaT, LeakTaugex);

  logic [DW-1:0] ram [0:255];
  logic [DW-1:0] ram_rd_data = '0;
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  assign GexRdData = ram_rd_data;

  always @(posedge clk) begin
    if (GexRdEn) ram_rd_data <= ram[GexRdAddr];
    if (GexWrEn) ram[GexWrAddr] <= GexWrData;
    if (bd_we)   ram[bd_addr] <= bd_data;
  end

  // ------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  int rel      = 0;
  bit checking = 1'b0;

  logic [DW-1:0] ref_mem [0:255];
  logic [W-1:0]  exp_q [$];

  logic          exp_busy     [0:MAXC-1];
  logic          exp_rd_en    [0:MAXC-1];
  logic [AW-1:0] exp_rd_addr  [0:MAXC-1];
  logic          exp_wr_en    [0:MAXC-1];
  logic [DW-1:0] exp_leak_gex [0:MAXC-1];
  logic          exp_done     [0:MAXC-1];
  logic          exp_err      [0:MAXC-1];
  logic          stall_at     [0:MAXC-1];

  logic [TW-1:0] pass_dt;
  logic [IW-1:0] pass_tau;
  int            done_c;
  int            obs_done;
  int            obs_wr;
  int            pend_n;
  logic [DW-1:0] pend_data [0:255];

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (rel cycle %0d): got %0h expected %0h", name, rel, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("busy",  Busy,    exp_busy[rel]);
      check("rd_en", GexRdEn, exp_rd_en[rel]);
      if (exp_rd_en[rel]) check("rd_addr", GexRdAddr, exp_rd_addr[rel]);
      check("wr_en", GexWrEn, exp_wr_en[rel]);
      if (GexWrEn) begin
        obs_wr++;
        check("wr_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("wr_addr_data", {GexWrAddr, GexWrData}, exp_q.pop_front());
        check("leak_gex", LeakGex, exp_leak_gex[rel]);
      end
      check("done",  Done,  exp_done[rel]);
      check("error", Error, exp_err[rel]);
      if (rel >= 1 && exp_busy[rel]) begin
        check("leak_dt",  LeakDeltaT, pass_dt);
        check("leak_tau", LeakTaugex, pass_tau);
      end
      if (Done && obs_done < 0) obs_done = rel;
    end
  end

  // ------------------------------------------------------------ model
  // Reads go to consecutive addresses in every non-stalled cycle from
  // cycle 1 until N are issued; each write trails its read by 2 cycles and
  // Done comes 3 cycles after the last read. Abort passes finish in cycle 1.
  task automatic build_model(input int n, input int dt, input logic [IW-1:0] tau);
    int c;
    int issued;
    exp_q.delete();
    for (int i = 0; i < MAXC; i++) begin
      exp_busy[i] = 0; exp_rd_en[i] = 0; exp_rd_addr[i] = '0;
      exp_wr_en[i] = 0; exp_leak_gex[i] = '0; exp_done[i] = 0; exp_err[i] = 0;
    end
    pass_dt  = TW'(dt);
    pass_tau = tau;
    pend_n   = 0;
    if (tau == 0 || n == 0) begin
      done_c = 1;
      exp_err[1] = (tau == 0);
    end else begin
      c = 1;
      issued = 0;
      while (issued < n && c < MAXC - 4) begin
        if (!stall_at[c]) begin
          exp_rd_en[c]      = 1;
          exp_rd_addr[c]    = AW'(issued);
          exp_wr_en[c+2]    = 1;
          exp_leak_gex[c+2] = ref_mem[issued];
          pend_data[issued] = leak_fn(ref_mem[issued], TW'(dt), tau);
          exp_q.push_back({AW'(issued), pend_data[issued]});
          issued++;
        end
        c++;
      end
      pend_n = issued;
      done_c = (c - 1) + 3;
    end
    for (int i = 1; i <= done_c; i++) exp_busy[i] = 1;
    exp_done[done_c] = 1;
    obs_done = -1;
    obs_wr   = 0;
  endtask

  task automatic apply_model();
    for (int i = 0; i < pend_n; i++) ref_mem[i] = pend_data[i];
  endtask

  // ---------------------------------------------------------- drivers
  // Called at posedge+1; leaves at posedge+1. dup_en adds an extra Start
  // pulse somewhere in cycles 1..done_c, which must be ignored.
  task automatic run_pass(input int n, input int dt, input logic [IW-1:0] tau,
                          input bit dup_en, input int stop_at);
    int dup_c;
    int last_c;
    build_model(n, dt, tau);
    dup_c  = dup_en ? int'($urandom_range(1, done_c)) : -1;
    last_c = (stop_at >= 0) ? stop_at : done_c + 2;
    checking = 1'b1;
    for (int cc = 0; cc <= last_c; cc++) begin
      rel   = cc;
      Start = (cc == 0) || (cc == dup_c);
      Stall = stall_at[cc];
      if (cc == 0) begin
        NumNeurons = (AW+1)'(n);
        DeltaT_In  = TW'(dt);
        Taugex_In  = tau;
      end else begin
        NumNeurons = (AW+1)'($urandom);
        DeltaT_In  = TW'($urandom);
        Taugex_In  = $urandom;
      end
      @(posedge clk); #1;
    end
    checking = 1'b0;
    Start = 1'b0;
    Stall = 1'b0;
    if (stop_at < 0) begin
      check("all_writes_seen", exp_q.size(), 0);
      apply_model();
    end
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < MAXC; i++) stall_at[i] = 1'b0;
  endtask

  task automatic ram_load(input int addr, input logic [DW-1:0] data);
    bd_we   = 1'b1;
    bd_addr = AW'(addr);
    bd_data = data;
    ref_mem[addr] = data;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"},   GexRdEn,    0);
    check({tag, "_rd_addr"}, GexRdAddr,  0);
    check({tag, "_wr_en"},   GexWrEn,    0);
    check({tag, "_wr_addr"}, GexWrAddr,  0);
    check({tag, "_wr_data"}, GexWrData,  0);
    check({tag, "_leakgex"}, LeakGex,    0);
    check({tag, "_leakdt"},  LeakDeltaT, 0);
    check({tag, "_leaktau"}, LeakTaugex, 0);
    check({tag, "_busy"},    Busy,       0);
    check({tag, "_done"},    Done,       0);
    check({tag, "_error"},   Error,      0);
  endtask

  localparam logic [DW-1:0] ONE    = 64'h0000_0001_0000_0000;
  localparam logic [DW-1:0] ONE_LK = 64'h0000_0000_F000_0000;

  // -------------------------------------------------------- sequence
  initial begin
    clear_stalls();
    #1 Reset = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_all_zero("por");
    @(posedge clk); #1;
    Reset = 1'b0;

    for (int i = 0; i < 256; i++) ram_load(i, {$urandom, $urandom});

    // N=4, DeltaT=1, Taugex=4, gex=1.0
    for (int i = 0; i < 4; i++) ram_load(i, ONE);
    run_pass(4, 1, 32'd4, 1'b0, -1);
    check("t1_done_cycle", obs_done, 7);
    check("t1_wr_count",   obs_wr,   4);
    for (int i = 0; i < 4; i++) check("t1_ram", ram[i], ONE_LK);

    // Same pass with Stall high in cycles 2-3
    for (int i = 0; i < 4; i++) ram_load(i, ONE);
    stall_at[2] = 1'b1;
    stall_at[3] = 1'b1;
    run_pass(4, 1, 32'd4, 1'b0, -1);
    clear_stalls();
    check("t2_done_cycle", obs_done, 9);
    check("t2_wr_count",   obs_wr,   4);
    for (int i = 0; i < 4; i++) check("t2_ram", ram[i], ONE_LK);

    // Taugex = 0 abort
    run_pass(8, 3, 32'd0, 1'b0, -1);
    check("t3_done_cycle", obs_done, 1);
    check("t3_wr_count",   obs_wr,   0);

    // N = 0 abort
    run_pass(0, 2, 32'd5, 1'b0, -1);
    check("t4_done_cycle", obs_done, 1);

    // Full address range
    run_pass(256, 2, 32'd6, 1'b0, -1);
    check("t5_done_cycle", obs_done, 259);
    check("t5_wr_count",   obs_wr,   256);

    // Randomised passes with stalls and ignored Start pulses
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < MAXC; i++) stall_at[i] = ($urandom_range(0, 3) == 0);
      run_pass(int'($urandom_range(1, 40)), int'($urandom_range(1, 15)),
               32'($urandom_range(0, 12)), 1'b1, -1);
      clear_stalls();
    end

    // Reset in cycle 3 of an N=10 pass, restart at cycle 6
    run_pass(10, 1, 32'd3, 1'b0, 2);
    rel = 3;
    #1 Reset = 1'b1;
    #1 check_all_zero("mid_reset");
    for (int cc = 3; cc <= 5; cc++) begin
      rel = cc;
      if (cc == 5) Reset = 1'b0;
      @(negedge clk);
      check("reset_no_wr", GexWrEn, 0);
      check("reset_no_rd", GexRdEn, 0);
      @(posedge clk); #1;
    end
    run_pass(10, 1, 32'd3, 1'b0, -1);
    check("t6_done_cycle", obs_done, 13);

    for (int i = 0; i < 256; i++) check("final_ram", ram[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gex_leak_scheduler.md
# gex_leak_scheduler

Sequences one shared combinational excitatory-conductance leak unit over a bank of neurons once per simulation timestep. On `Start` it streams every neuron's gex from the gex RAM through the leak unit and writes the decayed value back to the same address. It sustains one neuron per cycle and signals completion to the timestep controller.

## Interface
- `INTEGER_WIDTH`, 32: integer bits of the fixed-point format.
- `DATA_WIDTH_FRAC`, 32: fractional bits.
- `DATA_WIDTH`, `INTEGER_WIDTH + DATA_WIDTH_FRAC`: width of a gex word.
- `DELTAT_WIDTH`, 4: width of the timestep value.
- `NEURON_ADDR_WIDTH`, 8: gex RAM address width.

Ports:
- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-high.
- `Start` in 1: one-cycle pulse that begins a pass. Ignored while `Busy`.
- `NumNeurons` in `NEURON_ADDR_WIDTH+1`: number of neurons in the pass, sampled on `Start`.
- `DeltaT_In` in `DELTAT_WIDTH`: timestep, sampled on `Start`.
- `Taugex_In` in `INTEGER_WIDTH`: gex time constant, sampled on `Start`.
- `Stall` in 1: external arbiter holds off new RAM reads.
- `GexRdEn` out 1: gex RAM read enable.
- `GexRdAddr` out `NEURON_ADDR_WIDTH`: read address.
- `GexRdData` in `DATA_WIDTH`: RAM read data, valid one cycle after `GexRdEn`.
- `LeakGex` out `DATA_WIDTH`: operand gex presented to the leak unit.
- `LeakDeltaT` out `DELTAT_WIDTH`: DeltaT operand to the leak unit.
- `LeakTaugex` out `INTEGER_WIDTH`: Taugex operand to the leak unit.
- `LeakGexOut` in `DATA_WIDTH`: combinational result from the leak unit.
- `GexWrEn` out 1: gex RAM write enable.
- `GexWrAddr` out `NEURON_ADDR_WIDTH`: write address.
- `GexWrData` out `DATA_WIDTH`: write data.
- `Busy` out 1: high from the cycle after an accepted `Start` until `Done`.
- `Done` out 1: one-cycle completion pulse.
- `Error` out 1: one-cycle pulse coincident with `Done` when the pass is aborted.

## Operation
- FSM states:
  - IDLE: accepts `Start`.
  - RUN: issues reads.
  - DRAIN: waits for in-flight items to write back.
  - FINISH: pulses `Done`, then returns to IDLE.
- On `Start` in IDLE, latch `NumNeurons`, `DeltaT_In` and `Taugex_In`. `LeakDeltaT`/`LeakTaugex` hold the latched values until the next accepted `Start`.
- Abort cases, entered directly from IDLE to FINISH with no RAM access:
  - `Taugex_In == 0`: `Error` pulses with `Done`.
  - `NumNeurons == 0`: plain `Done`, no `Error`.
- Read stage (RUN):
  - Each cycle with `Stall` low: `GexRdEn=1`, `GexRdAddr` = read counter, counter increments.
  - When `Stall` is high: `GexRdEn=0` and the counter holds.
  - After read `NumNeurons-1` is issued, go to DRAIN.
- Operand stage: a read valid bit delayed by one cycle. When set, register `GexRdData` into `LeakGex` and the address into the stage-1 address register.
- Write stage: a stage-1 valid bit delayed by one cycle. When set, `GexWrEn=1`, `GexWrAddr` = stage-1 address, `GexWrData` = `LeakGexOut`.
- `Stall` never freezes in-flight items. Stalls only insert bubbles, and read and write addresses stay matched.
- DRAIN exits to FINISH when both stage valid bits are clear.
- A write to address k and a read of address k+2 occur in the same cycle. The RAM handles these as distinct addresses; no forwarding is needed.
- Reset, at any time including mid-pass:
  - State returns to IDLE and counters and valid bits clear.
  - All outputs go to 0 (`LeakGex`, `LeakDeltaT` and `LeakTaugex` included).
  - The in-flight write is dropped.

## Timing
- Start accepted at cycle 0, no stalls, N ≥ 1:
  - `Busy` is high from cycle 1 and falls in the cycle after `Done`.
  - Reads in cycles 1..N, writes in cycles 3..N+2.
  - `Done` in cycle N+3.
- Each stall cycle during RUN adds exactly one cycle to `Done`.
- Abort cases: `Done` (and `Error` if set) in cycle 1, `Busy` high only in cycle 1.
- Per-neuron latency is read → write = 2 cycles. `LeakGex` is stable for the whole write cycle, so the leak unit has one full cycle of combinational time.
- `Start` asserted during `Busy` or in the FINISH cycle is dropped. It is not queued.

## Test plan
- N=4, DeltaT=1, Taugex=4, RAM gex = 1.0 at addr 0..3:
  - RdEn in cycles 1–4 and WrEn in cycles 3–6.
  - Writes land at addr 0..3 with data `LeakGexOut` (model: 0.9375 = 0x0000_0000_F000_0000 for 64-bit).
  - Done in cycle 7.
- Same pass with `Stall` high in cycles 2–3:
  - Reads at addr 0 in cycle 1, then addr 1..3 in cycles 4–6.
  - Writes in order 0,1,2,3 with no duplicates.
  - Done in cycle 9.
- `Taugex_In=0`, N=8: no RdEn/WrEn; Done=Error=1 in cycle 1.
- N=0: Done in cycle 1, Error=0, no RAM access.
- N=256 (full address range, `NumNeurons=9'h100`): read addresses 0..255 with no wrap to 0, 256 writes, Done in cycle 259.
- Reset asserted at cycle 3 of an N=10 pass:
  - Asynchronously all outputs go to 0, and there are no further writes.
  - `Start` at cycle 6 restarts from addr 0.
